// File: rtl/freq_eq_para_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// freq_eq_para_ctrl : host load/readback controller for the equalizer coefficient RAM
// Optional readback path: define FREQ_EQ_READBACK_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module freq_eq_para_ctrl #(
  parameter int BITWIDTH  = 7,
  parameter int FFT_POINT = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [BITWIDTH+1:0]   cfg_addr,
  input  logic [15:0]           cfg_data,
  input  logic                  cfg_last,
  input  logic                  rb_req,
  input  logic [BITWIDTH+1:0]   rb_addr,
  output logic                  rb_valid,
  output logic [15:0]           rb_data,
  input  logic                  en_sync_in,
  output logic [BITWIDTH+1:0]   para_waddr,
  output logic                  w_en0,
  output logic [15:0]           para_in,
  output logic [BITWIDTH+1:0]   para_raddr,
  output logic                  r_en0,
  input  logic [15:0]           para_out,
  output logic                  busy,
  output logic                  load_done,
  output logic                  len_err
);

  localparam int c_aw = BITWIDTH + 2;
  localparam int c_cw = BITWIDTH + 3;
  localparam logic [c_cw-1:0] c_fft_point = c_cw'(FFT_POINT);

`ifdef FREQ_EQ_READBACK_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, RD_ISSUE = 3'd2, RD_WAIT = 3'd3, RD_CAPT = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1
  } state_t;
`endif

  state_t            r_state, w_next_state;
  logic [c_cw-1:0]   r_cnt;
  logic [c_cw-1:0]   w_cnt_inc;
  logic              w_cfg_acc;
  logic              r_w_en0, r_load_done, r_len_err;
  logic [c_aw-1:0]   r_waddr;
  logic [15:0]       r_wdata;

  // Coefficients may only change between frames.
  assign cfg_ready = ((r_state == IDLE) || (r_state == LOAD)) && !en_sync_in;
  assign w_cfg_acc = cfg_valid && cfg_ready;
  assign w_cnt_inc = r_cnt + c_cw'(1);
  assign busy      = (r_state != IDLE);

`ifdef FREQ_EQ_READBACK_EN
  logic w_rb_acc;
  // A simultaneous write request takes priority; the read stays pending.
  assign w_rb_acc = rb_req && (r_state == IDLE) && !en_sync_in && !cfg_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_cfg_acc)      w_next_state = cfg_last ? IDLE : LOAD;
`ifdef FREQ_EQ_READBACK_EN
        else if (w_rb_acc)  w_next_state = RD_ISSUE;
`endif
      end
      LOAD:     if (w_cfg_acc && cfg_last) w_next_state = IDLE;
`ifdef FREQ_EQ_READBACK_EN
      RD_ISSUE: w_next_state = RD_WAIT;
      RD_WAIT:  w_next_state = RD_CAPT;
      RD_CAPT:  w_next_state = IDLE;
`endif
      default:  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_w_en0     <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_load_done <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_w_en0     <= w_cfg_acc;
      r_load_done <= 1'b0;
      if (w_cfg_acc) begin
        r_waddr <= cfg_addr;
        r_wdata <= cfg_data;
        if (cfg_last) begin
          r_cnt <= '0;
          if (w_cnt_inc == c_fft_point) begin
            r_load_done <= 1'b1;
            r_len_err   <= 1'b0;
          end else begin
            r_len_err   <= 1'b1;
          end
        end else begin
          // Overlong table: keep writing, hold the count, flag the error.
          if (r_cnt != c_fft_point) r_cnt <= w_cnt_inc;
          if (w_cnt_inc >= c_fft_point) r_len_err <= 1'b1;
        end
      end
    end
  end

  assign w_en0      = r_w_en0;
  assign para_waddr = r_waddr;
  assign para_in    = r_wdata;
  assign load_done  = r_load_done;
  assign len_err    = r_len_err;

`ifdef FREQ_EQ_READBACK_EN
  logic              r_r_en0, r_rb_valid;
  logic [c_aw-1:0]   r_raddr;
  logic [15:0]       r_rb_data;

  // r_en0 is high exactly while in RD_ISSUE; data is captured on leaving RD_CAPT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r_en0    <= 1'b0;
      r_raddr    <= '0;
      r_rb_valid <= 1'b0;
      r_rb_data  <= '0;
    end else begin
      r_r_en0    <= w_rb_acc;
      if (w_rb_acc) r_raddr <= rb_addr;
      r_rb_valid <= (r_state == RD_CAPT);
      if (r_state == RD_CAPT) r_rb_data <= para_out;
    end
  end

  assign r_en0      = r_r_en0;
  assign para_raddr = r_raddr;
  assign rb_valid   = r_rb_valid;
  assign rb_data    = r_rb_data;
`else
  logic w_unused_rb;
  assign w_unused_rb = &{1'b0, rb_req, rb_addr, para_out};
  assign r_en0       = 1'b0;
  assign para_raddr  = '0;
  assign rb_valid    = 1'b0;
  assign rb_data     = '0;
`endif

endmodule
`default_nettype wire
